// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and defaults for the CPU-to-Arduino memory bus sequencer.
// Optional feature macro used by this slice: MEM_BUS_TIMEOUT_EN.
package mem_bus_pkg;

  typedef logic [15:0] word_t;
  typedef logic [7:0]  byte_t;

  localparam int SYNC_STAGES_DEF    = 2;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR_HI  = 3'd1,
    ST_ADDR_LO  = 3'd2,
    ST_WDATA_HI = 3'd3,
    ST_WDATA_LO = 3'd4,
    ST_RDATA_HI = 3'd5,
    ST_RDATA_LO = 3'd6,
    ST_DONE     = 3'd7
  } mem_bus_state_t;

  // A byte state is one in which a byte is moving on the external bus.
  function automatic logic is_byte_state(input logic [2:0] s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: core-side request/response port of mem_bus_ctrl.
//
// Handshake: a request transfers on a cycle where req_valid && req_ready
// (req_ready is high only while the controller is idle). The response has no
// back-pressure: resp_valid is a single-cycle pulse carrying resp_rdata and
// resp_err; resp_rdata keeps the last read value between read completions.
interface mem_bus_ctrl_if;
  import mem_bus_pkg::*;

  logic  req_valid;
  logic  req_ready;
  logic  req_we;
  logic  req_fetch;
  word_t req_addr;
  word_t req_wdata;
  logic  resp_valid;
  word_t resp_rdata;
  logic  resp_err;

  // Control-unit side.
  modport master (
    output req_valid, req_we, req_fetch, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Controller side.
  modport slave (
    input  req_valid, req_we, req_fetch, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ard_sync.sv
// ard_sync: SYNC_STAGES-deep synchronizer for the Arduino strobe plus a
// WIDTH-bit data vector, with a rising-edge detector on the synced strobe.
module ard_sync #(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ard_clk,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             tick
);

  // Strobe travels in the top bit so it stays aligned with its data.
  logic [WIDTH:0] sync_q [SYNC_STAGES];
  logic [WIDTH:0] sync_d [SYNC_STAGES];
  logic           clk_prev_q;
  logic           clk_prev_d;
  logic           clk_s;

  // Shift chain: pins enter stage 0, each later stage copies its predecessor.
  always_comb begin
    sync_d[0] = {ard_clk, data_i};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign clk_s      = sync_q[SYNC_STAGES-1][WIDTH];
  assign clk_prev_d = clk_s;
  assign data_o     = sync_q[SYNC_STAGES-1][WIDTH-1:0];
  // Pulse for the single cycle where the synced strobe is high but was low.
  assign tick       = clk_s & ~clk_prev_q;

  // Synchronizer and edge-history registers, all cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      clk_prev_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      clk_prev_q <= clk_prev_d;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: serializes each 16-bit CPU access into address bytes then data
// bytes on the 8-bit Arduino bus, one byte per ard_clk strobe.
// Optional per-byte abort timer: define MEM_BUS_TIMEOUT_EN.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF
`ifdef MEM_BUS_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic           clk,
  input  logic           rst,
  mem_bus_ctrl_if.slave  bus,
  input  logic           ard_clk,
  input  logic           ard_data_ready,
  input  logic           ard_receive_ready,
  input  byte_t          in_bus,
  output byte_t          out_bus,
  output logic           bus_pc,
  output logic           bus_mar,
  output logic           bus_mdr,
  output mem_bus_state_t dbg_state
);

  localparam logic [2:0] S_IDLE     = ST_IDLE;
  localparam logic [2:0] S_ADDR_HI  = ST_ADDR_HI;
  localparam logic [2:0] S_ADDR_LO  = ST_ADDR_LO;
  localparam logic [2:0] S_WDATA_HI = ST_WDATA_HI;
  localparam logic [2:0] S_WDATA_LO = ST_WDATA_LO;
  localparam logic [2:0] S_RDATA_HI = ST_RDATA_HI;
  localparam logic [2:0] S_RDATA_LO = ST_RDATA_LO;
  localparam logic [2:0] S_DONE     = ST_DONE;

  logic  tick;
  logic  data_ready_s;
  logic  receive_ready_s;
  byte_t in_bus_s;

  ard_sync #(
    .WIDTH       (10),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .ard_clk (ard_clk),
    .data_i  ({ard_data_ready, ard_receive_ready, in_bus}),
    .data_o  ({data_ready_s, receive_ready_s, in_bus_s}),
    .tick    (tick)
  );

  logic [2:0] state_q, state_d;
  word_t      addr_q, addr_d;
  word_t      wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       fetch_q, fetch_d;
  byte_t      rhi_q, rhi_d;
  word_t      rdata_q, rdata_d;

  logic       byte_ok;
  logic       data_ok;
  assign byte_ok = tick & receive_ready_s;
  assign data_ok = tick & data_ready_s;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Next-state and datapath: one byte advances per qualified strobe.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    fetch_d = fetch_q;
    rhi_d   = rhi_q;
    rdata_d = rdata_q;
`ifdef MEM_BUS_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          we_d    = bus.req_we;
          // A write is never a fetch, so the PC tag only appears on reads.
          fetch_d = bus.req_fetch & ~bus.req_we;
          state_d = S_ADDR_HI;
`ifdef MEM_BUS_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_ADDR_HI:  if (byte_ok) state_d = S_ADDR_LO;
      S_ADDR_LO:  if (byte_ok) state_d = we_q ? S_WDATA_HI : S_RDATA_HI;
      S_WDATA_HI: if (byte_ok) state_d = S_WDATA_LO;
      S_WDATA_LO: if (byte_ok) state_d = S_DONE;
      S_RDATA_HI: begin
        if (data_ok) begin
          rhi_d   = in_bus_s;
          state_d = S_RDATA_LO;
        end
      end
      S_RDATA_LO: begin
        if (data_ok) begin
          rdata_d = {rhi_q, in_bus_s};
          state_d = S_DONE;
        end
      end
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
`ifdef MEM_BUS_TIMEOUT_EN
    // A byte that never completes aborts the access; read data is left alone.
    if (is_byte_state(state_q) && (state_d == state_q) && (cnt_q == CNT_LAST)) begin
      state_d = S_DONE;
      err_d   = 1'b1;
    end
    cnt_d = ((state_d != state_q) || !is_byte_state(state_q)) ? '0 : cnt_q + 1'b1;
`endif
  end

  // Output decode: bus byte and exactly one tag in byte states, all zero otherwise.
  always_comb begin
    out_bus = '0;
    bus_pc  = 1'b0;
    bus_mar = 1'b0;
    bus_mdr = 1'b0;
    case (state_q)
      S_ADDR_HI: begin
        out_bus = addr_q[15:8];
        bus_pc  = fetch_q;
        bus_mar = ~fetch_q;
      end
      S_ADDR_LO: begin
        out_bus = addr_q[7:0];
        bus_pc  = fetch_q;
        bus_mar = ~fetch_q;
      end
      S_WDATA_HI: begin
        out_bus = wdata_q[15:8];
        bus_mdr = 1'b1;
      end
      S_WDATA_LO: begin
        out_bus = wdata_q[7:0];
        bus_mdr = 1'b1;
      end
      S_RDATA_HI, S_RDATA_LO: bus_mdr = 1'b1;
      default: ;
    endcase
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.resp_rdata = rdata_q;
`ifdef MEM_BUS_TIMEOUT_EN
  assign bus.resp_err   = (state_q == S_DONE) & err_q;
`else
  assign bus.resp_err   = 1'b0;
`endif
  assign dbg_state      = mem_bus_state_t'(state_q);

  // State and captured request registers; reset abandons any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      fetch_q <= 1'b0;
      rhi_q   <= '0;
      rdata_q <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      fetch_q <= fetch_d;
      rhi_q   <= rhi_d;
      rdata_q <= rdata_d;
`ifdef MEM_BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule
